// File: rtl/paddle_axis.sv
// Single-axis paddle controller with frame-based acceleration, saturating speed and
// clamping to [MIN_POS, MAX_POS]. Direction comes from buttons or from tracking a target.
module paddle_axis #(
    parameter int unsigned COORD_W      = 12,
    parameter int unsigned AXIS         = 0,
    parameter int unsigned HALF_LEN     = 80,
    parameter int unsigned HALF_THK     = 30,
    parameter int unsigned IPOS         = 320,
    parameter int unsigned ICROSS       = 440,
    parameter int unsigned MIN_POS      = 80,
    parameter int unsigned MAX_POS      = 560,
    parameter int unsigned MAX_SPEED    = 4,
    parameter int unsigned SPEED_W      = 4,
    parameter int unsigned ACCEL_FRAMES = 8,
    parameter int unsigned DEADBAND     = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ani_stb,
    input  logic               i_animate,
    input  logic               i_auto,
    input  logic               i_neg_btn,
    input  logic               i_pos_btn,
    input  logic [COORD_W-1:0] i_target,
    output logic [COORD_W-1:0] o_x1,
    output logic [COORD_W-1:0] o_x2,
    output logic [COORD_W-1:0] o_y1,
    output logic [COORD_W-1:0] o_y2,
    output logic [1:0]         o_dir,
    output logic [SPEED_W-1:0] o_speed,
    output logic               o_at_min,
    output logic               o_at_max
);

    typedef enum logic [1:0] {DirPos = 2'd0, DirNeg = 2'd1, DirNone = 2'd2} dir_e;

    localparam int unsigned ExtW = COORD_W + 1;
    localparam int unsigned AccW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    localparam logic [ExtW-1:0]    MinExt   = ExtW'(MIN_POS);
    localparam logic [ExtW-1:0]    MaxExt   = ExtW'(MAX_POS);
    localparam logic [ExtW-1:0]    DbExt    = ExtW'(DEADBAND);
    localparam logic [COORD_W-1:0] MinPos   = COORD_W'(MIN_POS);
    localparam logic [COORD_W-1:0] MaxPos   = COORD_W'(MAX_POS);
    localparam logic [COORD_W-1:0] IPos     = COORD_W'(IPOS);
    localparam logic [COORD_W-1:0] HalfLen  = COORD_W'(HALF_LEN);
    localparam logic [COORD_W-1:0] HalfThk  = COORD_W'(HALF_THK);
    localparam logic [COORD_W-1:0] Cross    = COORD_W'(ICROSS);
    localparam logic [SPEED_W-1:0] SpeedMax = SPEED_W'(MAX_SPEED);
    localparam logic [AccW-1:0]    AccLast  = AccW'(ACCEL_FRAMES - 1);

    logic [COORD_W-1:0] pos_q, pos_d;
    dir_e               dir_q, dir_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [AccW-1:0]    acc_q, acc_d;

    logic               tick;
    dir_e               req;
    logic [ExtW-1:0]    pos_ext, tgt_ext, spd_ext, step_up;
    logic [COORD_W-1:0] pos_mv;
    logic               clipped;

    always_comb begin
        tick    = i_ani_stb && i_animate && !i_rst;
        pos_ext = {1'b0, pos_q};
        tgt_ext = {1'b0, i_target};
        spd_ext = ExtW'(speed_q);
        step_up = pos_ext + spd_ext;

        req = DirNone;
        if (i_auto) begin
            if (tgt_ext > pos_ext + DbExt) begin
                req = DirPos;
            end else if (tgt_ext + DbExt < pos_ext) begin
                req = DirNeg;
            end
        end else begin
            unique case ({i_pos_btn, i_neg_btn})
                2'b10:   req = DirPos;
                2'b01:   req = DirNeg;
                default: req = DirNone;
            endcase
        end

        // Movement uses the velocity latched on the previous frame.
        pos_mv  = pos_q;
        clipped = 1'b0;
        case (dir_q)
            DirPos: begin
                if (step_up > MaxExt) begin
                    pos_mv  = MaxPos;
                    clipped = 1'b1;
                end else begin
                    pos_mv = step_up[COORD_W-1:0];
                end
            end
            DirNeg: begin
                if (pos_ext < MinExt + spd_ext) begin
                    pos_mv  = MinPos;
                    clipped = 1'b1;
                end else begin
                    pos_mv = pos_q - COORD_W'(speed_q);
                end
            end
            default: ;
        endcase

        pos_d   = pos_q;
        dir_d   = dir_q;
        speed_d = speed_q;
        acc_d   = acc_q;
        if (tick) begin
            pos_d = pos_mv;
            if (req == DirNone) begin
                dir_d   = DirNone;
                speed_d = '0;
                acc_d   = '0;
            end else if (req != dir_q) begin
                dir_d   = req;
                speed_d = SPEED_W'(1);
                acc_d   = '0;
            end else if (speed_q == '0) begin
                speed_d = SPEED_W'(1);
                acc_d   = '0;
            end else if (acc_q == AccLast) begin
                speed_d = (speed_q >= SpeedMax) ? SpeedMax : speed_q + 1'b1;
                acc_d   = '0;
            end else begin
                acc_d = acc_q + 1'b1;
            end
            // Hitting a wall kills momentum but keeps the requested direction.
            if (clipped) begin
                speed_d = '0;
                acc_d   = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pos_q   <= IPos;
            dir_q   <= DirNone;
            speed_q <= '0;
            acc_q   <= '0;
        end else begin
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
            acc_q   <= acc_d;
        end
    end

    assign o_dir    = dir_q;
    assign o_speed  = speed_q;
    assign o_at_min = (pos_q == MinPos);
    assign o_at_max = (pos_q == MaxPos);

    generate
        if (AXIS == 0) begin : g_horiz
            assign o_x1 = pos_q - HalfLen;
            assign o_x2 = pos_q + HalfLen;
            assign o_y1 = Cross - HalfThk;
            assign o_y2 = Cross + HalfThk;
        end else begin : g_vert
            assign o_y1 = pos_q - HalfLen;
            assign o_y2 = pos_q + HalfLen;
            assign o_x1 = Cross - HalfThk;
            assign o_x2 = Cross + HalfThk;
        end
    endgenerate

endmodule

// File: doc/paddle_axis.md
# paddle_axis

Parametrised paddle controller, successor to the fixed-speed single-axis paddle. One instance drives one paddle on a selectable axis (horizontal or vertical). Each animation frame it applies a direction request taken either from buttons (manual mode) or from a target coordinate (auto/CPU mode). It adds frame-based acceleration, saturating speed and underflow-safe clamping to configurable bounds. It sits between input conditioning / ball logic and the renderer, and outputs the paddle bounding box.

## Interface
Parameters:
- COORD_W, 12, coordinate width in bits
- AXIS, 0, movement axis: 0 = x (horizontal), 1 = y (vertical)
- HALF_LEN, 80, half-length along the movement axis
- HALF_THK, 30, half-thickness across the axis
- IPOS, 320, reset centre position along the axis
- ICROSS, 440, fixed centre position across the axis
- MIN_POS, 80, lowest legal centre position (must be ≥ HALF_LEN)
- MAX_POS, 560, highest legal centre position
- MAX_SPEED, 4, speed ceiling in pixels/frame (≥ 1)
- SPEED_W, 4, width of the speed register
- ACCEL_FRAMES, 8, consecutive same-direction frames per +1 speed step (≥ 1)
- DEADBAND, 4, auto-mode tolerance in pixels

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_ani_stb  in  1  animation strobe, one i_clk cycle per frame
- i_animate  in  1  enables frame updates
- i_auto  in  1  1 = track i_target, 0 = use buttons
- i_neg_btn  in  1  request movement toward MIN_POS
- i_pos_btn  in  1  request movement toward MAX_POS
- i_target  in  COORD_W  auto-mode target centre
- o_x1, o_x2, o_y1, o_y2  out  COORD_W each  bounding box (left, right, top, bottom)
- o_dir  out  2  current direction: 0 = POS, 1 = NEG, 2 = NONE
- o_speed  out  SPEED_W  current speed
- o_at_min  out  1  pos == MIN_POS
- o_at_max  out  1  pos == MAX_POS

## Operation
- State: pos (COORD_W), dir (2), speed (SPEED_W), acc_cnt (counter 0..ACCEL_FRAMES-1).
- Reset values: pos = IPOS, dir = 2, speed = 0, acc_cnt = 0. The box outputs follow from these; o_at_min/o_at_max are derived from IPOS.
- A frame tick is i_ani_stb && i_animate && !i_rst. On all other cycles, every register holds its value.
- Request (req) for the frame:
  - Manual mode: pos_btn only → POS; neg_btn only → NEG; both or neither → NONE.
  - Auto mode: i_target > pos + DEADBAND → POS; i_target + DEADBAND < pos → NEG; otherwise NONE.
  - Comparisons are done at COORD_W+1 bits, with no wrap.
- Movement on a tick uses the pre-tick dir and speed:
  - POS: pos ← min(pos + speed, MAX_POS).
  - NEG: pos ← (pos < MIN_POS + speed) ? MIN_POS : pos − speed.
  - NONE: pos unchanged.
- Velocity update on the same tick, in priority order:
  - req == NONE → dir = 2, speed = 0, acc_cnt = 0.
  - req ≠ dir → dir = req, speed = 1, acc_cnt = 0.
  - req == dir and speed == 0 → speed = 1, acc_cnt = 0.
  - req == dir otherwise:
    - if acc_cnt == ACCEL_FRAMES−1: speed = min(speed + 1, MAX_SPEED) and acc_cnt = 0;
    - else acc_cnt + 1.
- Clamp: if the movement step was clipped to a bound, speed ← 0 and acc_cnt ← 0. This overrides the velocity update; dir keeps its updated value.
- Mode switches (i_auto) take effect at the next tick; no state is flushed.
- Box outputs:
  - AXIS = 0: o_x1 = pos − HALF_LEN, o_x2 = pos + HALF_LEN, o_y1 = ICROSS − HALF_THK, o_y2 = ICROSS + HALF_THK.
  - AXIS = 1: the same with x and y swapped.

## Timing
- All state updates occur on the i_clk edge of a tick cycle. Box, o_at_min and o_at_max are combinational from registers, valid in the cycle after the edge.
- A request sampled at tick k first moves the paddle at tick k+1 (one-frame latency).
- i_rst asserted on a tick cycle wins. Reset mid-motion restores reset values on the next edge.
- i_animate low freezes everything, including acc_cnt.
- Held request, starting from rest (ACCEL_FRAMES = 8): speed becomes 1 at tick 1 and 2 at tick 9, then +1 every 8 ticks, saturating at MAX_SPEED.

## Test plan
- Reset: assert i_rst with i_ani_stb high → pos 320, o_dir 2, o_speed 0, o_x1 240, o_x2 400, o_y1 410, o_y2 470.
- Manual hold pos_btn for 10 ticks from reset:
  - o_speed: 1 at tick 1, 2 at tick 9;
  - pos: 320 after tick 1, 321 after tick 2, 328 after tick 9, 330 after tick 10.
- Both buttons held → o_dir 2, o_speed 0, pos unchanged. Reversal (POS at speed 3, then neg_btn only) → at that tick pos += 3, speed 1, dir 1.
- Clamp at max: pos 558, speed 4, dir POS, tick with pos_btn → pos 560, o_at_max 1, o_speed 0. Next tick: speed 1, pos stays 560.
- Clamp at min (no underflow, MIN_POS 80): pos 82, speed 4, dir NEG → pos 80, o_at_min 1.
- Auto mode, i_target 400, pos 320 → dir POS until pos ≥ 396, then NONE. Moving i_target to 330 → dir NEG. With i_animate low, 20 strobes → no change.
